// File: rtl/ahbl_arb2m1s_pkg.sv
// Shared AHB-Lite encodings and the buffered address-phase record used by the 2:1 arbiter.
package ahbl_arb2m1s_pkg;

  localparam logic [1:0] HtransIdle   = 2'b00;
  localparam logic [1:0] HtransBusy   = 2'b01;
  localparam logic [1:0] HtransNonseq = 2'b10;
  localparam logic [1:0] HtransSeq    = 2'b11;

  localparam logic [2:0] HsizeByte  = 3'b000;
  localparam logic [2:0] HsizeHalf  = 3'b001;
  localparam logic [2:0] HsizeWord  = 3'b010;
  localparam logic [2:0] HsizeDword = 3'b011;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
  } ahbl_addr_t;

  // Picks the winning master id from a 2-bit request vector. On contention, round-robin
  // favours the master that did not win last; fixed priority always favours M0.
  function automatic logic arb_pick(logic [1:0] req, logic last_gnt, bit rr);
    return (req == 2'b11) ? (rr & ~last_gnt) : req[1];
  endfunction

endpackage

// File: rtl/ahbl_arb2m1s_if.sv
// AHB-Lite single-port bundle. The master modport drives the address/data phase,
// the slave modport returns ready and read data.
interface ahbl_arb2m1s_if #(
  parameter int unsigned DW = 64
);
  logic [31:0]   haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [DW-1:0] hwdata;
  logic          hready;
  logic [DW-1:0] hrdata;

  modport master (
    output haddr, htrans, hwrite, hsize, hwdata,
    input  hready, hrdata
  );

  modport slave (
    input  haddr, htrans, hwrite, hsize, hwdata,
    output hready, hrdata
  );
endinterface

// File: rtl/ahbl_arb2m1s_req_hold.sv
// Holds one master's address phase that could not be forwarded, until it is issued.
module ahbl_arb2m1s_req_hold
  import ahbl_arb2m1s_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic       clr_i,
  input  ahbl_addr_t addr_i,
  output logic       valid_o,
  output ahbl_addr_t addr_o
);

  logic       valid_q, valid_d;
  ahbl_addr_t addr_q, addr_d;

  // Load a new request or retire the held one once the slave has taken it.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    if (load_i) begin
      valid_d = 1'b1;
      addr_d  = addr_i;
    end else if (clr_i) begin
      valid_d = 1'b0;
    end
  end

  // Pending-request state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;

endmodule

// File: rtl/ahbl_arb2m1s.sv
// Two-master to one-slave AHB-Lite arbiter. Requests that cannot go straight to the slave are
// buffered per master and replayed; the owning master is stalled through its hready.
module ahbl_arb2m1s
  import ahbl_arb2m1s_pkg::*;
#(
  parameter int unsigned DW    = 64,
  parameter bit          ArbRr = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  ahbl_arb2m1s_if.slave  m0_io,
  ahbl_arb2m1s_if.slave  m1_io,
  ahbl_arb2m1s_if.master s_io
);

  logic [1:0] live, pend_vld, req, load, clr;
  ahbl_addr_t live_a0, live_a1, pend_a0, pend_a1, src;
  logic       gnt_vld, gnt_id, issue;
  logic       hready_m0, hready_m1;
  logic       dp_valid_q, dp_valid_d, dp_id_q, dp_id_d;
  logic       last_gnt_q, last_gnt_d, ap_lock_q, ap_lock_d, ap_id_q, ap_id_d;

  assign live_a0 = '{addr: m0_io.haddr, write: m0_io.hwrite, size: m0_io.hsize};
  assign live_a1 = '{addr: m1_io.haddr, write: m1_io.hwrite, size: m1_io.hsize};

  // SEQ is accepted like NONSEQ; bursts leave the arbiter as singles.
  assign live[0] = ((m0_io.htrans == HtransNonseq) || (m0_io.htrans == HtransSeq)) & hready_m0;
  assign live[1] = ((m1_io.htrans == HtransNonseq) || (m1_io.htrans == HtransSeq)) & hready_m1;
  assign req     = pend_vld | live;

  ahbl_arb2m1s_req_hold u_hold_m0 (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (load[0]),
    .clr_i   (clr[0]),
    .addr_i  (live_a0),
    .valid_o (pend_vld[0]),
    .addr_o  (pend_a0)
  );

  ahbl_arb2m1s_req_hold u_hold_m1 (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (load[1]),
    .clr_i   (clr[1]),
    .addr_i  (live_a1),
    .valid_o (pend_vld[1]),
    .addr_o  (pend_a1)
  );

  // Grant: live or pending when the slave is ready; while stalled only pending requests may
  // be shown, and the first one shown stays locked so the address never moves mid-stall.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (s_io.hready) begin
      gnt_vld = |req;
      gnt_id  = arb_pick(req, last_gnt_q, ArbRr);
    end else if (ap_lock_q) begin
      gnt_vld = 1'b1;
      gnt_id  = ap_id_q;
    end else begin
      gnt_vld = |pend_vld;
      gnt_id  = arb_pick(pend_vld, last_gnt_q, ArbRr);
    end
  end

  // Source select: a buffered request always takes precedence over the master's live pins.
  always_comb begin
    if (gnt_id) begin
      src = pend_vld[1] ? pend_a1 : live_a1;
    end else begin
      src = pend_vld[0] ? pend_a0 : live_a0;
    end
  end

  assign issue   = gnt_vld & s_io.hready;
  assign load[0] = live[0] & ~(issue & ~gnt_id);
  assign load[1] = live[1] & ~(issue & gnt_id);
  assign clr[0]  = pend_vld[0] & issue & ~gnt_id;
  assign clr[1]  = pend_vld[1] & issue & gnt_id;

  // Data-phase ownership, arbitration history and stall lock.
  always_comb begin
    dp_valid_d = dp_valid_q;
    dp_id_d    = dp_id_q;
    last_gnt_d = last_gnt_q;
    ap_lock_d  = ap_lock_q;
    ap_id_d    = ap_id_q;
    if (s_io.hready) begin
      dp_valid_d = gnt_vld;
      dp_id_d    = gnt_id;
      ap_lock_d  = 1'b0;
      if (gnt_vld) begin
        last_gnt_d = gnt_id;
      end
    end else begin
      ap_lock_d = gnt_vld;
      ap_id_d   = gnt_id;
    end
  end

  // Arbiter state registers; last_gnt resets to M1 so M0 wins the first contention.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dp_valid_q <= 1'b0;
      dp_id_q    <= 1'b0;
      last_gnt_q <= 1'b1;
      ap_lock_q  <= 1'b0;
      ap_id_q    <= 1'b0;
    end else begin
      dp_valid_q <= dp_valid_d;
      dp_id_q    <= dp_id_d;
      last_gnt_q <= last_gnt_d;
      ap_lock_q  <= ap_lock_d;
      ap_id_q    <= ap_id_d;
    end
  end

  // Per-master ready: follow the slave during own data phase, stall while buffered.
  always_comb begin
    hready_m0 = 1'b1;
    hready_m1 = 1'b1;
    if (dp_valid_q && !dp_id_q) begin
      hready_m0 = s_io.hready;
    end else if (pend_vld[0]) begin
      hready_m0 = 1'b0;
    end
    if (dp_valid_q && dp_id_q) begin
      hready_m1 = s_io.hready;
    end else if (pend_vld[1]) begin
      hready_m1 = 1'b0;
    end
  end

  assign m0_io.hready = hready_m0;
  assign m1_io.hready = hready_m1;
  assign m0_io.hrdata = s_io.hrdata;
  assign m1_io.hrdata = s_io.hrdata;

  assign s_io.htrans = gnt_vld ? HtransNonseq : HtransIdle;
  assign s_io.haddr  = gnt_vld ? src.addr : 32'h0;
  assign s_io.hwrite = gnt_vld ? src.write : 1'b0;
  assign s_io.hsize  = gnt_vld ? src.size : 3'b000;
  assign s_io.hwdata = !dp_valid_q ? '0 : (dp_id_q ? m1_io.hwdata : m0_io.hwdata);

endmodule
